// File: rtl/equiv_pkg.sv
// Shared types and helpers for the equivalence miter monitor: FSM encoding,
// counter width and the saturating increment used by every counter.
package equiv_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_CHECK  = 2'd1,
    ST_FAILED = 2'd2
  } state_e;

  // Holds at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/equiv_skew_fifo.sv
// Per-side skew FIFO: absorbs latency differences between the two compared
// designs. Pointers carry one extra wrap bit so full and empty are distinct.
module equiv_skew_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when an entry leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; clearing the pointers empties the
  // FIFO and stale words are never read before being overwritten.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/equiv_miter_monitor.sv
// Equivalence miter monitor: aligns two output streams through skew FIFOs,
// compares popped pairs per channel and records the first divergence.
module equiv_miter_monitor
  import equiv_pkg::*;
#(
  parameter int WIDTH        = 91,
  parameter int CHANNELS     = 1,
  parameter int DEPTH        = 4,
  parameter int WARMUP       = 0,
  parameter int MASKED       = 0,
  parameter int STOP_ON_FAIL = 1,
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] y_1,
  input  logic                      v_1,
  input  logic [CHANNELS*WIDTH-1:0] y_2,
  input  logic                      v_2,
  input  logic [WIDTH-1:0]          cmp_mask,
  output logic                      mismatch,
  output logic                      fail,
  output logic [CH_W-1:0]           fail_chan,
  output logic [CNT_W-1:0]          fail_index,
  output logic [CNT_W-1:0]          pair_count,
  output logic [CNT_W-1:0]          err_count,
  output logic                      overflow
);

  localparam int DW = CHANNELS * WIDTH;

  logic [DW-1:0]       q_1, q_2;
  logic                full_1, empty_1, full_2, empty_2;
  logic                pop;
  logic                drop_1, drop_2;
  logic [WIDTH-1:0]    eff_mask;
  logic [CHANNELS-1:0] chan_diff;
  logic                pair_diff;
  logic [CH_W-1:0]     first_chan;
  state_e              state;
  logic [CNT_W-1:0]    warm_cnt;

  // Pairs leave only together, so the two streams stay index-aligned.
  assign pop    = !empty_1 && !empty_2;
  assign drop_1 = v_1 && full_1 && !pop;
  assign drop_2 = v_2 && full_2 && !pop;

  equiv_skew_fifo #(.WIDTH(DW), .DEPTH(DEPTH)) u_fifo_1 (
    .clk  (clk),
    .rst  (rst),
    .push (v_1),
    .pop  (pop),
    .din  (y_1),
    .dout (q_1),
    .full (full_1),
    .empty(empty_1)
  );

  equiv_skew_fifo #(.WIDTH(DW), .DEPTH(DEPTH)) u_fifo_2 (
    .clk  (clk),
    .rst  (rst),
    .push (v_2),
    .pop  (pop),
    .din  (y_2),
    .dout (q_2),
    .full (full_2),
    .empty(empty_2)
  );

  assign eff_mask = (MASKED != 0) ? cmp_mask : '1;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    assign chan_diff[c] = |((q_1[c*WIDTH +: WIDTH] ^ q_2[c*WIDTH +: WIDTH]) & eff_mask);
  end

  assign pair_diff = |chan_diff;

  // NOTE: every variable written here gets a default first so no latch is
  // inferred when no channel differs.
  always_comb begin
    first_chan = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (chan_diff[c]) first_chan = CH_W'(c);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its peers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if (WARMUP > 0) state <= ST_WARMUP;
      else            state <= ST_CHECK;
      warm_cnt   <= '0;
      mismatch   <= 1'b0;
      fail       <= 1'b0;
      fail_chan  <= '0;
      fail_index <= '0;
      pair_count <= '0;
      err_count  <= '0;
      overflow   <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      overflow <= overflow | drop_1 | drop_2;
      if (pop) begin
        unique case (state)
          ST_WARMUP: begin
            if (warm_cnt == CNT_W'(WARMUP - 1)) state <= ST_CHECK;
            else                                warm_cnt <= sat_inc(warm_cnt);
          end
          ST_CHECK: begin
            pair_count <= sat_inc(pair_count);
            if (pair_diff) begin
              mismatch  <= 1'b1;
              err_count <= sat_inc(err_count);
              if (!fail) begin
                fail       <= 1'b1;
                fail_chan  <= first_chan;
                fail_index <= pair_count;
              end
              if (STOP_ON_FAIL != 0) state <= ST_FAILED;
            end
          end
          default: ;  // FAILED: FIFOs drain, nothing else moves
        endcase
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!mismatch)
      else $info("equiv_miter_monitor: compared pair differs, err_count=%0d", err_count);
    end
  end
`endif

endmodule

// File: tb/tb_equiv_miter_monitor.sv
// Directed bench for equiv_miter_monitor: a cycle table plus hand sequences
// for skew, overflow, channel capture, masking and mid-run reset.
module tb_equiv_miter_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] y_1 = '0, y_2 = '0;
  logic        v_1 = 1'b0, v_2 = 1'b0;
  logic [7:0]  cmp_mask = 8'hFF;

  // dut: WARMUP=2, masked compare, stop on fail
  logic        a_mm, a_fail, a_ovf;
  logic [1:0]  a_chan;
  logic [15:0] a_idx, a_pc, a_ec;
  // dut0: no warmup, exact compare, keeps checking after a failure
  logic        b_mm, b_fail, b_ovf;
  logic [1:0]  b_chan;
  logic [15:0] b_idx, b_pc, b_ec;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  equiv_miter_monitor #(
    .WIDTH(8), .CHANNELS(4), .DEPTH(4), .WARMUP(2), .MASKED(1), .STOP_ON_FAIL(1)
  ) dut (
    .clk(clk), .rst(rst), .y_1(y_1), .v_1(v_1), .y_2(y_2), .v_2(v_2),
    .cmp_mask(cmp_mask), .mismatch(a_mm), .fail(a_fail), .fail_chan(a_chan),
    .fail_index(a_idx), .pair_count(a_pc), .err_count(a_ec), .overflow(a_ovf)
  );

  equiv_miter_monitor #(
    .WIDTH(8), .CHANNELS(4), .DEPTH(4), .WARMUP(0), .MASKED(0), .STOP_ON_FAIL(0)
  ) dut0 (
    .clk(clk), .rst(rst), .y_1(y_1), .v_1(v_1), .y_2(y_2), .v_2(v_2),
    .cmp_mask(cmp_mask), .mismatch(b_mm), .fail(b_fail), .fail_chan(b_chan),
    .fail_index(b_idx), .pair_count(b_pc), .err_count(b_ec), .overflow(b_ovf)
  );

  typedef struct {
    logic        v;
    logic [31:0] y1;
    logic [31:0] y2;
    logic        mm;
    logic [15:0] pc;
    logic [15:0] ec;
    logic        fail;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [31:0] a, input logic va, input logic [31:0] b, input logic vb);
    y_1 = a; v_1 = va; y_2 = b; v_2 = vb;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    v_1 = 1'b0; v_2 = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic v, input logic [31:0] y1, input logic [31:0] y2,
                              input logic mm, input int pc, input int ec, input logic fl);
    vec_t r;
    r.v = v; r.y1 = y1; r.y2 = y2; r.mm = mm;
    r.pc = 16'(pc); r.ec = 16'(ec); r.fail = fl;
    return r;
  endfunction

  initial begin
    // Pairs 0-1 differ but fall in warmup, pairs 2-11 equal, then a channel-1
    // difference that stops the checker, then a further ignored difference.
    tbl[0] = mk(1, 32'h00000000, 32'hFFFFFFFF, 0, 0, 0, 0);
    tbl[1] = mk(1, 32'h01010101, 32'hFEFEFEFE, 0, 0, 0, 0);
    for (int k = 2; k < 12; k++)
      tbl[k] = mk(1, 32'h01010101 * k, 32'h01010101 * k, 0, (k > 2) ? k - 2 : 0, 0, 0);
    tbl[12] = mk(0, 32'h0, 32'h0, 0, 10, 0, 0);
    tbl[13] = mk(0, 32'h0, 32'h0, 0, 10, 0, 0);
    tbl[14] = mk(1, 32'hA0A1A2A3, 32'hA0A1B2A3, 0, 10, 0, 0);
    tbl[15] = mk(0, 32'h0, 32'h0, 1, 11, 1, 1);
    tbl[16] = mk(0, 32'h0, 32'h0, 0, 11, 1, 1);
    tbl[17] = mk(1, 32'h12345678, 32'hEDCBA987, 0, 11, 1, 1);
    tbl[18] = mk(0, 32'h0, 32'h0, 0, 11, 1, 1);

    // Reset state, observed while rst is still asserted
    #1;
    check("rst.mismatch", a_mm, 0);
    check("rst.fail", a_fail, 0);
    check("rst.pair_count", a_pc, 0);
    check("rst.err_count", a_ec, 0);
    check("rst.overflow", a_ovf, 0);
    check("rst.fail_index", a_idx, 0);
    check("rst0.pair_count", b_pc, 0);
    do_reset();

    cmp_mask = 8'hFF;
    for (int i = 0; i < NV; i++) begin
      cyc(tbl[i].y1, tbl[i].v, tbl[i].y2, tbl[i].v);
      check($sformatf("tbl[%0d].mismatch", i), a_mm, tbl[i].mm);
      check($sformatf("tbl[%0d].pair_count", i), a_pc, tbl[i].pc);
      check($sformatf("tbl[%0d].err_count", i), a_ec, tbl[i].ec);
      check($sformatf("tbl[%0d].fail", i), a_fail, tbl[i].fail);
    end
    check("tbl.fail_chan", a_chan, 1);
    check("tbl.fail_index", a_idx, 10);
    check("tbl.overflow", a_ovf, 0);

    // Ten equal pairs, no warmup
    do_reset();
    for (int t = 0; t < 10; t++) cyc(32'h3C3C0000 + t, 1, 32'h3C3C0000 + t, 1);
    cyc(0, 0, 0, 0);
    check("eq10.pair_count0", b_pc, 10);
    check("eq10.err_count0", b_ec, 0);
    check("eq10.fail0", b_fail, 0);
    check("eq10.pair_count", a_pc, 8);

    // Side 2 lags by 3: the FIFO fills exactly to DEPTH, nothing is dropped
    do_reset();
    for (int t = 0; t < 11; t++)
      cyc(32'hC0C0C0C0 + t, t < 6, 32'hC0C0C0C0 + t - 3, (t >= 3) && (t < 9));
    check("lag3.overflow", a_ovf, 0);
    check("lag3.err_count", a_ec, 0);
    check("lag3.pair_count", a_pc, 4);
    check("lag3.pair_count0", b_pc, 6);
    check("lag3.err_count0", b_ec, 0);

    // Side 2 lags by 5: the fifth side-1 push hits a full FIFO
    do_reset();
    for (int t = 0; t < 4; t++) cyc(32'hD0 + t, 1, 0, 0);
    check("lag5.overflow_before", a_ovf, 0);
    cyc(32'hD4, 1, 0, 0);
    check("lag5.overflow", a_ovf, 1);
    check("lag5.overflow0", b_ovf, 1);
    cyc(32'hD5, 1, 32'hD0, 1);
    check("lag5.overflow_sticky", a_ovf, 1);

    // Compared pair 6 differs on channels 2 and 3
    do_reset();
    for (int t = 0; t < 8; t++) cyc(32'h01010101 * t, 1, 32'h01010101 * t, 1);
    cyc(32'h55555555, 1, 32'hAABB5555, 1);
    check("chan.mismatch_before", a_mm, 0);
    check("chan.pair_count_before", a_pc, 6);
    cyc(0, 0, 0, 0);
    check("chan.mismatch", a_mm, 1);
    check("chan.fail_chan", a_chan, 2);
    check("chan.fail_index", a_idx, 6);
    check("chan.pair_count", a_pc, 7);
    check("chan.fail_index0", b_idx, 8);
    check("chan.fail_chan0", b_chan, 2);
    cyc(32'h01020304, 1, 32'h01020305, 1);
    check("chan.mismatch_pulse", a_mm, 0);
    cyc(0, 0, 0, 0);
    check("chan.frozen_mismatch", a_mm, 0);
    check("chan.frozen_pair_count", a_pc, 7);
    check("chan.frozen_err_count", a_ec, 1);
    check("chan.mismatch0", b_mm, 1);
    check("chan.err_count0", b_ec, 2);
    check("chan.pair_count0", b_pc, 10);
    check("chan.kept_index0", b_idx, 8);
    check("chan.kept_chan0", b_chan, 2);

    // Masked compare: an all-zero mask hides every difference
    do_reset();
    cmp_mask = 8'h00;
    for (int t = 0; t < 4; t++) cyc(32'h12345678 + t, 1, ~(32'h12345678 + t), 1);
    cyc(32'h00000010, 1, 32'h00000011, 1);
    check("mask0.err_count", a_ec, 0);
    check("mask0.fail", a_fail, 0);
    check("mask0.pair_count", a_pc, 2);
    check("mask0.err_count0", b_ec, 4);
    cmp_mask = 8'h01;
    cyc(0, 0, 0, 0);
    check("mask1.fail", a_fail, 1);
    check("mask1.err_count", a_ec, 1);
    check("mask1.fail_index", a_idx, 2);
    check("mask1.fail_chan", a_chan, 0);
    check("mask1.err_count0", b_ec, 5);

    // Reset while side 1 holds two entries: clears at once, leaves no stale pair
    cyc(32'h77, 1, 0, 0);
    cyc(32'h78, 1, 0, 0);
    rst = 1'b1;
    #1;
    check("arst.fail", a_fail, 0);
    check("arst.err_count", a_ec, 0);
    check("arst.pair_count", a_pc, 0);
    check("arst.fail_index", a_idx, 0);
    check("arst.fail_chan", a_chan, 0);
    check("arst.fail0", b_fail, 0);
    check("arst.err_count0", b_ec, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(0, 0, 32'h99, 1);
    cyc(0, 0, 0, 0);
    check("arst.no_pop0", b_pc, 0);
    check("arst.no_mismatch0", b_mm, 0);
    check("arst.no_err0", b_ec, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/equiv_miter_monitor.md
EQUIV_MITER_MONITOR -- requirements
Module: equiv_miter_monitor

Interface
REQ-001 Parameter WIDTH, default 91, sets the bit width of one compared channel.
REQ-002 Parameter CHANNELS, default 1, sets the number of independent channels per side.
REQ-003 Parameter DEPTH, default 4 (power of two, >=2), sets the per-side skew FIFO depth.
REQ-004 Parameter WARMUP, default 0, sets the count of leading pairs discarded uncompared.
REQ-005 Parameter MASKED, default 0: 0 = exact compare; 1 = compare under cmp_mask.
REQ-006 Parameter STOP_ON_FAIL, default 1: 1 = freeze comparison after the first mismatch.
REQ-007 clk  input  1  sole clock; all state updates on posedge clk.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 y_1  input  CHANNELS*WIDTH  side-1 outputs; channel c occupies bits [c*WIDTH +: WIDTH].
REQ-010 v_1  input  1  side-1 sample valid.
REQ-011 y_2  input  CHANNELS*WIDTH  side-2 outputs, same packing as y_1.
REQ-012 v_2  input  1  side-2 sample valid.
REQ-013 cmp_mask  input  WIDTH  bits set to 1 are compared; ignored when MASKED=0.
REQ-014 mismatch  output  1  one-cycle pulse for each compared pair that differs.
REQ-015 fail  output  1  sticky: set by the first mismatch.
REQ-016 fail_chan  output  max(1,clog2(CHANNELS))  lowest-indexed mismatching channel of the first failing pair.
REQ-017 fail_index  output  16  compared-pair index of the first failure.
REQ-018 pair_count  output  16  count of compared pairs; saturates at 16'hFFFF.
REQ-019 err_count  output  16  count of mismatching pairs; saturates.
REQ-020 overflow  output  1  sticky: a push was dropped because a FIFO was full.

Function
REQ-021 Each side SHALL have its own DEPTH-entry FIFO; a valid sample is pushed when v_x=1.
REQ-022 A push to a full FIFO SHALL be dropped and SHALL set overflow, unless that FIFO pops in the same cycle, in which case the push is accepted.
REQ-023 When both FIFOs are non-empty in a cycle, one entry SHALL pop from each as a pair; neither side pops alone.
REQ-024 When a FIFO is empty, no pop SHALL occur, including when both v_1 and v_2 are high that cycle.
REQ-025 A pair popped in cycle t SHALL produce mismatch, count and fail updates in cycle t+1 (latency 1).
REQ-026 A channel differs when (a^b)!=0 for MASKED=0, or when ((a^b)&cmp_mask)!=0 for MASKED=1; the pair mismatches if any channel differs.
REQ-027 FSM states: WARMUP, CHECK, FAILED; reset state is WARMUP, or CHECK if WARMUP=0.
REQ-028 WARMUP: popped pairs are discarded uncounted; after the WARMUP-th pop, the FSM SHALL go to CHECK.
REQ-029 CHECK: each pair increments pair_count; on a mismatch, err_count increments.
REQ-030 On the first mismatch, the block SHALL capture fail_chan and fail_index (the pre-increment pair_count) and set fail.
REQ-031 On a mismatch with STOP_ON_FAIL=1, CHECK SHALL go to FAILED; with STOP_ON_FAIL=0 it SHALL stay in CHECK.
REQ-032 FAILED: FIFOs keep draining; pair_count, err_count, mismatch and captured fields SHALL freeze; only rst exits.
REQ-033 Counters SHALL saturate at all-ones, with no wrap-around.
REQ-034 FIFO pointers SHALL wrap modulo DEPTH and carry an extra bit to distinguish full from empty.
REQ-035 In simulation builds, an immediate assertion SHALL fire in any cycle where mismatch=1.

Reset
REQ-036 rst SHALL asynchronously clear FIFOs, pointers, FSM, all counters, fail, fail_chan, fail_index, overflow and mismatch to 0.
REQ-037 rst asserted mid-operation SHALL discard in-flight FIFO contents; the first post-reset pair is a warmup pair when WARMUP>0.

Structure
REQ-038 Package equiv_pkg SHALL hold the FSM state enum, CNT_W=16, and the saturating-increment function.
REQ-039 Sub-module equiv_skew_fifo (parameters WIDTH*CHANNELS and DEPTH; push, pop, full, empty) SHALL be instantiated once per side.

Verification
REQ-040 Scenario: v_1 and v_2 both high for 10 cycles with equal data -> pair_count=10, err_count=0, fail=0.
REQ-041 Scenario: side 2 lags side 1 by 3 cycles with DEPTH=4 and equal data -> no mismatch and overflow=0; with a lag of 5 cycles -> overflow=1.
REQ-042 Scenario: CHANNELS=4, pair 6 has channels 2 and 3 differing -> mismatch one cycle after the pop, fail_chan=2, fail_index=6, FSM in FAILED.
REQ-043 Scenario: MASKED=1, cmp_mask=0, all data differs -> err_count=0; cmp_mask bit0=1 with bit0 differing -> fail=1.
REQ-044 Scenario: WARMUP=2, pairs 0-1 differ and pair 2 is equal -> fail=0, pair_count=1.
REQ-045 Scenario: rst pulsed while FIFOs hold 2 entries -> all outputs 0 immediately, with no pop on the next cycle.
